branch_predict_unit: RTL and testbench

Parametrised successor to the execute-stage branch unit. It adds a direct-mapped branch history/target table that predicts fetch-stage control flow with 2-bit saturating counters. It resolves branch, jal and jalr in execute, including the correct jalr target, and raises a redirect on misprediction. It sits between the fetch PC mux (prediction side) and the execute stage (resolution side).

---
 rtl/bpu_pkg.sv | 22 ++
 rtl/bpu_table.sv | 57 +++++
 rtl/branch_predict_unit.sv | 85 ++++++++
 tb/tb_branch_predict_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared types for the branch predict unit: counter encoding and table entry layout.
package bpu_pkg;
  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'd0;
  localparam ctr_t CTR_WNT = 2'd1;
  localparam ctr_t CTR_WT  = 2'd2;
  localparam ctr_t CTR_ST  = 2'd3;

  // Tag and target are held zero-extended so one entry type serves every PC_W/IDX_W.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    ctr_t        ctr;
    logic [31:0] target;
  } bpu_entry_t;

  function automatic ctr_t ctr_step(input ctr_t c, input logic up);
    if (up) return (c == CTR_ST)  ? CTR_ST  : ctr_t'(c + 2'd1);
    else    return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'd1);
  endfunction
endpackage

// File: rtl/bpu_table.sv
// Direct-mapped predictor storage: one combinational read port, one read-modify-write
// update port keyed by the resolving instruction, asynchronous reset.
module bpu_table
  import bpu_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] rd_idx,
  output bpu_entry_t       rd_entry,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_tag,
  input  logic [31:0]      wr_target,
  input  logic             upd_en,
  input  logic             upd_taken,
  input  logic             upd_jump,
  input  logic             inv_en
);
  localparam int DEPTH = 1 << IDX_W;

  bpu_entry_t mem [DEPTH];
  bpu_entry_t cur, nxt;
  logic       wr_en, hit;

  assign rd_entry = mem[rd_idx];
  assign cur      = mem[wr_idx];

  always_comb begin
    nxt   = cur;
    wr_en = 1'b0;
    hit   = cur.valid && (cur.tag == wr_tag);
    if (upd_en) begin
      if (hit) begin
        wr_en   = 1'b1;
        nxt.ctr = upd_jump ? CTR_ST : ctr_step(cur.ctr, upd_taken);
        if (upd_taken) nxt.target = wr_target;
      end else if (upd_taken) begin
        wr_en = 1'b1;
        nxt   = '{valid: 1'b1, tag: wr_tag, ctr: (upd_jump ? CTR_ST : CTR_WT), target: wr_target};
      end
    end else if (inv_en && hit) begin
      // non-control instruction aliased onto a live entry: drop it
      wr_en     = 1'b1;
      nxt.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '{valid: 1'b0, tag: '0, ctr: CTR_WNT, target: '0};
    end else if (wr_en) begin
      mem[wr_idx] <= nxt;
    end
  end
endmodule

// File: rtl/branch_predict_unit.sv
// Fetch-side branch prediction plus execute-side resolution and redirect.
// Define BPU_STATS_EN to add the resolved/mispredict counters and their ports.
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int PC_W  = 9,
  parameter int IDX_W = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [PC_W-1:0] f_pc,
  output logic            f_pred_taken,
  output logic [31:0]     f_pred_target,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [31:0]     ex_imm,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic            ex_jalr,
  input  logic [31:0]     ex_alu_result,
  input  logic            ex_pred_taken,
  input  logic [31:0]     ex_pred_target,
  output logic [31:0]     ex_pc_four,
  output logic            redirect,
  output logic [31:0]     redirect_pc
`ifdef BPU_STATS_EN
  ,
  output logic [31:0]     stat_resolved,
  output logic [31:0]     stat_mispredict
`endif
);
  logic [IDX_W-1:0] f_idx, ex_idx;
  logic [31:0]      f_tag, ex_tag, target;
  logic             f_hit, is_ctl, res, taken, inv_en;
  logic             unused_pc_lsbs;
  bpu_entry_t       f_entry;

  assign f_idx          = f_pc[IDX_W+1:2];
  assign f_tag          = 32'(f_pc[PC_W-1:IDX_W+2]);
  assign ex_idx         = ex_pc[IDX_W+1:2];
  assign ex_tag         = 32'(ex_pc[PC_W-1:IDX_W+2]);
  assign unused_pc_lsbs = ^f_pc[1:0];

  assign f_hit         = f_entry.valid && (f_entry.tag == f_tag);
  assign f_pred_taken  = f_hit && f_entry.ctr[1];
  assign f_pred_target = f_hit ? f_entry.target : 32'd0;

  assign is_ctl     = ex_branch | ex_jump | ex_jalr;
  assign res        = ex_valid & is_ctl;
  assign inv_en     = ex_valid & ~is_ctl;
  assign taken      = ex_jump | ex_jalr | (ex_branch & ex_alu_result[0]);
  assign target     = ex_jalr ? {ex_alu_result[31:1], 1'b0} : 32'(ex_pc) + ex_imm;
  assign ex_pc_four = 32'(ex_pc) + 32'd4;

  // A valid non-control instruction predicted taken hit a stale alias and must fall through.
  assign redirect    = res ? ((taken != ex_pred_taken) || (taken && (target != ex_pred_target)))
                           : (ex_valid && ex_pred_taken);
  assign redirect_pc = taken ? target : ex_pc_four;

  bpu_table #(.IDX_W(IDX_W)) u_table (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_idx    (f_idx),
    .rd_entry  (f_entry),
    .wr_idx    (ex_idx),
    .wr_tag    (ex_tag),
    .wr_target (32'(target[PC_W-1:0])),
    .upd_en    (res),
    .upd_taken (taken),
    .upd_jump  (ex_jump | ex_jalr),
    .inv_en    (inv_en)
  );

`ifdef BPU_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_resolved   <= '0;
      stat_mispredict <= '0;
    end else begin
      if (res)      stat_resolved   <= stat_resolved + 32'd1;
      if (redirect) stat_mispredict <= stat_mispredict + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed plus randomized bench for branch_predict_unit against an array-based reference model.
module tb_branch_predict_unit;
  localparam int PC_W = 9;
  localparam int IDX_W = 4;
  localparam int N = 16;

  logic            clk, reset_n;
  logic [PC_W-1:0] f_pc, ex_pc;
  logic            f_pred_taken, ex_valid, ex_branch, ex_jump, ex_jalr, ex_pred_taken, redirect;
  logic [31:0]     f_pred_target, ex_imm, ex_alu_result, ex_pred_target, ex_pc_four, redirect_pc;
`ifdef BPU_STATS_EN
  logic [31:0]     stat_resolved, stat_mispredict;
`endif

  branch_predict_unit #(.PC_W(PC_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset_n(reset_n), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .f_pred_target(f_pred_target), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jalr(ex_jalr), .ex_alu_result(ex_alu_result),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target), .ex_pc_four(ex_pc_four),
    .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef BPU_STATS_EN
    , .stat_resolved(stat_resolved), .stat_mispredict(stat_mispredict)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference table: plain arrays indexed by pc/4 mod 16
  bit          mv   [N];
  int unsigned mtag [N];
  int          mctr [N];
  logic [31:0] mtgt [N];
  int unsigned s_res, s_mis;

  // pending resolution of the current cycle, applied to the model at the edge
  bit          m_res, m_taken, m_jump, m_inv, m_redir;
  logic [31:0] m_tgt;
  int          m_idx;
  int unsigned m_tag;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0; mtag[i] = 0; mctr[i] = 1; mtgt[i] = 0;
    end
    s_res = 0; s_mis = 0;
    m_res = 0; m_redir = 0; m_inv = 0;
  endtask

  task automatic model_pred(input logic [PC_W-1:0] pc, output logic pt, output logic [31:0] ptg);
    int i;
    bit hit;
    i   = (int'(pc) / 4) % N;
    hit = mv[i] && (mtag[i] == int'(pc) / 64);
    pt  = hit && (mctr[i] >= 2);
    ptg = hit ? mtgt[i] : 32'd0;
  endtask

  // cls = {jalr, jump, branch}
  task automatic apply(input logic [PC_W-1:0] fpc, input logic v, input logic [PC_W-1:0] pc,
                       input logic [31:0] imm, input logic [2:0] cls, input logic [31:0] alu,
                       input logic pt, input logic [31:0] ptg);
    logic        e_pt;
    logic [31:0] e_ptg, rpc;
    f_pc = fpc; ex_valid = v; ex_pc = pc; ex_imm = imm;
    ex_branch = cls[0]; ex_jump = cls[1]; ex_jalr = cls[2];
    ex_alu_result = alu; ex_pred_taken = pt; ex_pred_target = ptg;
    #1;
    model_pred(fpc, e_pt, e_ptg);
    check("f_pred_taken", {31'd0, f_pred_taken}, {31'd0, e_pt});
    check("f_pred_target", f_pred_target, e_ptg);
    m_res   = v && (cls != 3'b000);
    m_taken = cls[1] || cls[2] || (cls[0] && alu[0]);
    m_jump  = cls[1] || cls[2];
    m_tgt   = cls[2] ? (alu & ~32'd1) : (32'(pc) + imm);
    m_redir = m_res ? ((m_taken != pt) || (m_taken && (m_tgt != ptg))) : (v && pt);
    m_inv   = v && (cls == 3'b000);
    m_idx   = (int'(pc) / 4) % N;
    m_tag   = int'(pc) / 64;
    rpc     = (m_res && m_taken) ? m_tgt : 32'(pc) + 32'd4;
    check("ex_pc_four", ex_pc_four, 32'(pc) + 32'd4);
    check("redirect", {31'd0, redirect}, {31'd0, m_redir});
    if (m_redir) check("redirect_pc", redirect_pc, rpc);
  endtask

  task automatic tick();
    bit hit;
    int i;
    @(posedge clk);
    if (reset_n) begin
      i   = m_idx;
      hit = mv[i] && (mtag[i] == m_tag);
      if (m_res) begin
        if (hit) begin
          if (m_jump)       mctr[i] = 3;
          else if (m_taken) mctr[i] = (mctr[i] == 3) ? 3 : mctr[i] + 1;
          else              mctr[i] = (mctr[i] == 0) ? 0 : mctr[i] - 1;
          if (m_taken) mtgt[i] = m_tgt % 512;
        end else if (m_taken) begin
          mv[i] = 1; mtag[i] = m_tag; mtgt[i] = m_tgt % 512; mctr[i] = m_jump ? 3 : 2;
        end
      end else if (m_inv && hit) begin
        mv[i] = 0;
      end
      if (m_res)   s_res++;
      if (m_redir) s_mis++;
    end
    @(negedge clk);
  endtask

  initial begin
    logic        pt;
    logic [31:0] ptg, r, imm, alu;
    logic [2:0]  cls;
    logic [PC_W-1:0] pc;
    int sel;

    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    apply(9'h010, 0, 9'h0, 32'd0, 3'b000, 32'd0, 0, 32'd0);
    check("reset_pred_taken", {31'd0, f_pred_taken}, 32'd0);
    check("reset_pred_target", f_pred_target, 32'd0);
`ifdef BPU_STATS_EN
    check("reset_stat_res", stat_resolved, 32'd0);
    check("reset_stat_mis", stat_mispredict, 32'd0);
`endif
    tick();
    reset_n = 1'b1;

    // taken branch allocates, then predicts
    apply(9'h000, 1, 9'h010, 32'h20, 3'b001, 32'd1, 0, 32'd0);
    check("plan_br_redirect", {31'd0, redirect}, 32'd1);
    check("plan_br_rpc", redirect_pc, 32'h30);
    tick();
    apply(9'h010, 0, 9'h0, 32'd0, 3'b000, 32'd0, 0, 32'd0);
    check("plan_pred_taken", {31'd0, f_pred_taken}, 32'd1);
    check("plan_pred_target", f_pred_target, 32'h30);
    tick();

    // two not-taken resolutions walk ctr 2->1->0
    apply(9'h010, 1, 9'h010, 32'h20, 3'b001, 32'd0, 1, 32'h30);
    check("plan_nt1_rpc", redirect_pc, 32'h14);
    tick();
    apply(9'h010, 1, 9'h010, 32'h20, 3'b001, 32'd0, 1, 32'h30);
    check("plan_nt2_redirect", {31'd0, redirect}, 32'd1);
    check("plan_nt2_rpc", redirect_pc, 32'h14);
    tick();
    apply(9'h010, 0, 9'h0, 32'd0, 3'b000, 32'd0, 0, 32'd0);
    check("plan_nt_pred", {31'd0, f_pred_taken}, 32'd0);
    tick();

    // jalr target clears bit 0
    apply(9'h000, 1, 9'h040, 32'h4, 3'b100, 32'h85, 0, 32'd0);
    check("plan_jalr_rpc", redirect_pc, 32'h84);
    check("plan_jalr_four", ex_pc_four, 32'h44);
    tick();

    // aliasing: 0x50 shares idx with 0x10 and takes over the entry
    apply(9'h000, 1, 9'h050, 32'h10, 3'b001, 32'd1, 0, 32'd0);
    tick();
    apply(9'h010, 0, 9'h0, 32'd0, 3'b000, 32'd0, 0, 32'd0);
    check("plan_alias_miss", f_pred_target, 32'd0);
    tick();
    apply(9'h050, 0, 9'h0, 32'd0, 3'b000, 32'd0, 0, 32'd0);
    check("plan_alias_hit", f_pred_target, 32'h60);
    tick();

    // stale alias: non-control predicted taken redirects to pc+4 and invalidates
    apply(9'h000, 1, 9'h050, 32'd0, 3'b000, 32'd0, 1, 32'h60);
    check("plan_stale_rpc", redirect_pc, 32'h54);
    tick();
    apply(9'h050, 0, 9'h0, 32'd0, 3'b000, 32'd0, 0, 32'd0);
    check("plan_stale_inv", {31'd0, f_pred_taken}, 32'd0);
    tick();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      pc  = PC_W'($urandom) & ~PC_W'(3);
      sel = $urandom_range(0, 4);
      cls = (sel == 1 || sel == 4) ? 3'b001 : (sel == 2) ? 3'b010 : (sel == 3) ? 3'b100 : 3'b000;
      r   = $urandom;
      imm = ($urandom_range(0, 3) == 0) ? r : ({{22{r[9]}}, r[9:0]} & ~32'd3);
      alu = ($urandom_range(0, 1) == 1) ? $urandom : (32'($urandom_range(0, 511)));
      model_pred(pc, pt, ptg);
      if ($urandom_range(0, 3) == 0) begin
        pt  = 1'($urandom);
        ptg = $urandom_range(0, 1) ? ptg : 32'($urandom_range(0, 511));
      end
      apply(PC_W'($urandom) & ~PC_W'(3), ($urandom_range(0, 9) != 0), pc, imm, cls, alu, pt, ptg);
      tick();
    end
`ifdef BPU_STATS_EN
    check("stat_resolved", stat_resolved, s_res);
    check("stat_mispredict", stat_mispredict, s_mis);
`endif

    // reset landing while an update is pending: nothing is written
    apply(9'h100, 1, 9'h100, 32'h8, 3'b010, 32'd0, 0, 32'd0);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    ex_valid = 1'b0;
    reset_n  = 1'b1;
    for (int i = 0; i < N; i++) begin
      apply(PC_W'(i * 4) | 9'h100, 0, 9'h0, 32'd0, 3'b000, 32'd0, 0, 32'd0);
      tick();
    end
`ifdef BPU_STATS_EN
    check("rst_stat_res", stat_resolved, 32'd0);
    check("rst_stat_mis", stat_mispredict, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
